// File: rtl/rmw_request_port.sv
// Requester-side RMW port: buffers increment requests, issues read then write to the bank
// scheduler, re-issues conflicted accesses. Optional SAT_ADD_EN selects a saturating add.
module rmw_request_port #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_RETRY  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_incr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  conflict,
    output logic                  done_valid,
    output logic [ADDR_WIDTH-1:0] done_addr,
    output logic [DATA_WIDTH-1:0] done_data,
    output logic                  busy,
    output logic                  retry_err
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StWrw} stateT;

    stateT                 stateQ;
    logic [ADDR_WIDTH-1:0] fifoAddr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifoIncr [FIFO_DEPTH];
    logic [PtrW-1:0]       wrPtrQ, rdPtrQ;
    logic [CntW-1:0]       cntQ, cntD;
    logic [RetryW-1:0]     retryCntQ;
    logic                  retryErrQ;
    logic                  memReqQ, memWeQ;
    logic [ADDR_WIDTH-1:0] memAddrQ, addrQ;
    logic [DATA_WIDTH-1:0] memWdataQ, incrQ, sumQ, sumNext;
    logic                  push, pop, fifoEmpty;

    assign fifoEmpty = (cntQ == '0);
    assign req_ready = (cntQ != CntW'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (stateQ == StIdle) && !fifoEmpty;

`ifdef SAT_ADD_EN
    logic [DATA_WIDTH:0] rawSum;
    assign rawSum  = {1'b0, mem_rdata} + {1'b0, incrQ};
    assign sumNext = rawSum[DATA_WIDTH] ? '1 : rawSum[DATA_WIDTH-1:0];
`else
    assign sumNext = mem_rdata + incrQ;
`endif

    always_comb begin
        cntD = cntQ;
        if (push && !pop) begin
            cntD = cntQ + CntW'(1);
        end else if (pop && !push) begin
            cntD = cntQ - CntW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtrQ] <= req_addr;
            fifoIncr[wrPtrQ] <= req_incr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            cntQ      <= '0;
            retryCntQ <= '0;
            retryErrQ <= 1'b0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            addrQ     <= '0;
            incrQ     <= '0;
            sumQ      <= '0;
        end else begin
            cntQ      <= cntD;
            retryErrQ <= 1'b0;
            if (push) begin
                wrPtrQ <= wrPtrQ + PtrW'(1);
            end
            // Conflict only matters in the cycle after an access was issued.
            if ((stateQ == StRdw || stateQ == StWrw) && conflict &&
                retryCntQ != RetryW'(MAX_RETRY)) begin
                retryCntQ <= retryCntQ + RetryW'(1);
                if (retryCntQ == RetryW'(MAX_RETRY - 1)) begin
                    retryErrQ <= 1'b1;
                end
            end
            case (stateQ)
                StIdle: begin
                    if (!fifoEmpty) begin
                        addrQ    <= fifoAddr[rdPtrQ];
                        incrQ    <= fifoIncr[rdPtrQ];
                        memAddrQ <= fifoAddr[rdPtrQ];
                        rdPtrQ   <= rdPtrQ + PtrW'(1);
                        memReqQ  <= 1'b1;
                        memWeQ   <= 1'b0;
                        stateQ   <= StRd;
                    end
                end
                StRd: begin
                    memReqQ <= 1'b0;
                    stateQ  <= StRdw;
                end
                StRdw: begin
                    memReqQ <= 1'b1;
                    if (conflict) begin
                        stateQ <= StRd;
                    end else begin
                        sumQ      <= sumNext;
                        memWdataQ <= sumNext;
                        memWeQ    <= 1'b1;
                        retryCntQ <= '0;
                        stateQ    <= StWr;
                    end
                end
                StWr: begin
                    memReqQ   <= 1'b0;
                    memWeQ    <= 1'b0;
                    memWdataQ <= '0;
                    stateQ    <= StWrw;
                end
                StWrw: begin
                    if (conflict) begin
                        memReqQ   <= 1'b1;
                        memWeQ    <= 1'b1;
                        memWdataQ <= sumQ;
                        stateQ    <= StWr;
                    end else begin
                        retryCntQ <= '0;
                        memAddrQ  <= '0;
                        stateQ    <= StIdle;
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign mem_req    = memReqQ;
    assign mem_we     = memWeQ;
    assign mem_addr   = memAddrQ;
    assign mem_wdata  = memWdataQ;
    assign retry_err  = retryErrQ;
    assign busy       = (stateQ != StIdle) || !fifoEmpty;
    // A commit coinciding with reset is discarded.
    assign done_valid = (stateQ == StWrw) && !conflict && !rst;
    assign done_addr  = done_valid ? addrQ : '0;
    assign done_data  = done_valid ? sumQ : '0;

endmodule

// File: tb/tb_rmw_request_port.sv
// Scoreboard bench for rmw_request_port; the bench also plays the bank scheduler.
module tb_rmw_request_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [12:0] req_addr = '0;
    logic [31:0] req_incr = '0;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [31:0] mem_rdata = '0;
    logic        conflict = 1'b0;
    logic        done_valid;
    logic [12:0] done_addr;
    logic [31:0] done_data;
    logic        busy;
    logic        retry_err;

    rmw_request_port dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_incr(req_incr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req), .mem_rdata(mem_rdata),
        .conflict(conflict), .done_valid(done_valid), .done_addr(done_addr),
        .done_data(done_data), .busy(busy), .retry_err(retry_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [12:0] a;
        logic [31:0] d;
    } expT;

    expT         expQ[$];
    int          doneCycLog[$];
    logic [31:0] wrLog[$];
    logic [31:0] memModel [32];
    int checks = 0, failures = 0;
    int cyc = 0, reads = 0, writes = 0, lastWrCyc = 0, doneCnt = 0, lastDoneCyc = 0, errCnt = 0;
    int rdConfl = 0, wrConfl = 0;
    bit holdConflict = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scheduler model: answers an access issued in cycle N during cycle N+1.
    initial begin
        logic        iss, isWe;
        logic [12:0] a;
        logic [31:0] wd;
        forever begin
            @(negedge clk);
            iss  = mem_req;
            isWe = mem_we;
            a    = mem_addr;
            wd   = mem_wdata;
            if (!mem_we) check("wdata_idle", mem_wdata, 0);
            if (iss && !isWe) reads++;
            if (iss && isWe) begin
                writes++;
                wrLog.push_back(wd);
                lastWrCyc = cyc;
            end
            @(posedge clk);
            #1;
            conflict  = 1'b0;
            mem_rdata = '0;
            if (holdConflict) begin
                conflict = 1'b1;
            end else if (iss && !isWe && rdConfl > 0) begin
                conflict = 1'b1;
                rdConfl--;
            end else if (iss && isWe && wrConfl > 0) begin
                conflict = 1'b1;
                wrConfl--;
            end
            if (iss && !isWe && !conflict) mem_rdata = memModel[a[4:0]];
            if (iss && isWe && !conflict) memModel[a[4:0]] = wd;
        end
    end

    // Completion monitor.
    initial forever begin
        @(negedge clk);
        if (retry_err) errCnt++;
        if (done_valid) begin
            if (expQ.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                expT e;
                e = expQ.pop_front();
                check("done_addr", done_addr, e.a);
                check("done_data", done_data, e.d);
            end
            doneCnt++;
            lastDoneCyc = cyc;
            doneCycLog.push_back(cyc);
        end
    end

    task automatic pushReq(input logic [12:0] a, input logic [31:0] inc, output int pc);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_incr  = inc;
        guard = 0;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("push_timeout", 1, 0);
        pc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic expect1(input logic [12:0] a, input logic [31:0] d);
        expT e;
        e.a = a;
        e.d = d;
        expQ.push_back(e);
    endtask

    task automatic waitDone(input int n);
        int guard;
        guard = 0;
        while (doneCnt < n && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (doneCnt < n) check("done_timeout", doneCnt, n);
    endtask

    task automatic clearStats();
        reads = 0;
        writes = 0;
        wrLog.delete();
    endtask

    initial begin
        int pc, p0, pe, base, guard;
        for (int i = 0; i < 32; i++) memModel[i] = 32'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_ctrl", {mem_req, mem_we, done_valid, retry_err, busy}, 0);
        check("rst_bus", {mem_addr, mem_wdata, done_addr, done_data}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: clean RMW
        memModel[5] = 32'd10;
        clearStats();
        expect1(13'd5, 32'd13);
        pushReq(13'd5, 32'd3, pc);
        waitDone(1);
        check("t1_wr_cyc", lastWrCyc, pc + 4);
        check("t1_done_cyc", lastDoneCyc, pc + 5);
        check("t1_reads", reads, 1);
        check("t1_writes", writes, 1);
        check("t1_wdata", wrLog[0], 32'd13);
        @(negedge clk);
        check("t1_idle_addr", mem_addr, 0);
        check("t1_idle_busy", busy, 0);

        // 2: two read conflicts
        memModel[7] = 32'd100;
        clearStats();
        errCnt  = 0;
        rdConfl = 2;
        expect1(13'd7, 32'd101);
        pushReq(13'd7, 32'd1, pc);
        waitDone(2);
        check("t2_done_cyc", lastDoneCyc, pc + 9);
        check("t2_reads", reads, 3);
        check("t2_writes", writes, 1);
        check("t2_retry_err", errCnt, 0);

        // 3: one write conflict, no re-read
        memModel[9] = 32'd50;
        clearStats();
        wrConfl = 1;
        expect1(13'd9, 32'd55);
        pushReq(13'd9, 32'd5, pc);
        waitDone(3);
        check("t3_done_cyc", lastDoneCyc, pc + 7);
        check("t3_reads", reads, 1);
        check("t3_writes", writes, 2);
        check("t3_wdata0", wrLog[0], 32'd55);
        check("t3_wdata1", wrLog[1], 32'd55);

        // 4: fill the buffer while the FSM is stalled on conflicts
        for (int i = 10; i < 16; i++) memModel[i] = 32'(i * 16);
        holdConflict = 1;
        base = doneCnt;
        expect1(13'd10, 32'd161);
        pushReq(13'd10, 32'd1, p0);
        expect1(13'd11, 32'd178);
        pushReq(13'd11, 32'd2, pc);
        expect1(13'd12, 32'd195);
        pushReq(13'd12, 32'd3, pc);
        expect1(13'd13, 32'd212);
        pushReq(13'd13, 32'd4, pc);
        check("t4_ready_3", req_ready, 1);
        expect1(13'd14, 32'd229);
        pushReq(13'd14, 32'd5, pc);
        @(negedge clk);
        check("t4_full", req_ready, 0);
        check("t4_busy", busy, 1);
        holdConflict = 0;
        expect1(13'd15, 32'd246);
        pushReq(13'd15, 32'd6, pe);
        waitDone(base + 6);
        check("t4_late_push", pe, doneCycLog[base] + 2);
        check("t4_throughput", doneCycLog[base + 2] - doneCycLog[base + 1], 5);

        // 5: overflow behaviour
        memModel[20] = 32'hFFFF_FFFE;
`ifdef SAT_ADD_EN
        expect1(13'd20, 32'hFFFF_FFFF);
`else
        expect1(13'd20, 32'h0000_0002);
`endif
        pushReq(13'd20, 32'd4, pc);
        waitDone(base + 7);
        check("t5_mem", memModel[20], expQ.size() == 0 ? done_data_last() : 32'h0);

        // 6: persistent conflicts, then reset during the write wait
        errCnt = 0;
        holdConflict = 1;
        pushReq(13'd21, 32'd2, pc);
        repeat (40) @(negedge clk);
        check("t6_retry_err_once", errCnt, 1);
        holdConflict = 0;
        guard = 0;
        while (!(mem_req && mem_we) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("t6_reach_wr", mem_we, 1);
        base = doneCnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_ctrl", {mem_req, mem_we, done_valid, retry_err, busy}, 0);
        check("t6_bus", {mem_addr, mem_wdata, done_addr, done_data}, 0);
        check("t6_ready", req_ready, 1);
        clearStats();
        repeat (20) @(negedge clk);
        check("t6_no_write", writes, 0);
        check("t6_no_done", doneCnt, base);
        check("sb_drain", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [31:0] done_data_last();
`ifdef SAT_ADD_EN
        return 32'hFFFF_FFFF;
`else
        return 32'h0000_0002;
`endif
    endfunction

endmodule
